// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock
// through a single full-subtractor cell and a borrow flip-flop.
//
//   state  | meaning
//   IDLE   | waiting for start; last result held on diff/bout
//   RUN    | one difference bit produced per clock (busy=1)
//   DONE   | result just presented, one-cycle done pulse; start may relaunch
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic cell_x, cell_y, cell_d, cell_bo;

    assign cell_x  = a_sr_q[0];
    assign cell_y  = b_sr_q[0];
    assign cell_d  = cell_x ^ cell_y ^ borrow_q;
    assign cell_bo = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & borrow_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = WIDTH'({cell_d, res_sr_q} >> 1);
                borrow_d = cell_bo;
                count_d  = count_q + CW'(1);
                // Last bit: publish the completed word and park the counter
                // at zero rather than letting it run past WIDTH-1.
                if (count_q == CW'(WIDTH - 1)) begin
                    diff_d  = res_sr_d;
                    bout_d  = cell_bo;
                    count_d = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus predicts accepted operations
// with plain arithmetic; a negedge monitor checks busy/done/diff/bout each cycle.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           e0;
        int           dc;
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    logic         rst_at_edge = 1'b1;
    int           free_edge = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] hold_d = '0;
    logic         hold_bo = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // One clock of stimulus; the operation model decides whether the edge accepts start.
    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic tr);
        int   e;
        exp_t x;
        @(posedge clk);
        #1;
        a     = ta;
        b     = tb_v;
        start = ts;
        reset = tr;
        e     = cyc + 1;
        if (tr) begin
            free_edge = 0;
        end else if (ts && e >= free_edge) begin
            x.e0 = e;
            x.dc = e + W;
            x.d  = ta - tb_v;
            x.bo = (ta < tb_v);
            sb.push_back(x);
            free_edge = e + W + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b0, 1'b0);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        drive(ta, tb_v, 1'b1, 1'b0);
        idle(W + 2);
    endtask

    always @(negedge clk) begin
        if (rst_at_edge) begin
            while (sb.size() > 0 && sb[0].e0 <= cyc) void'(sb.pop_front());
            hold_d  = '0;
            hold_bo = 1'b0;
            chk("reset_busy", int'(busy), 0);
            chk("reset_done", int'(done), 0);
            chk("reset_diff", int'(diff), 0);
            chk("reset_bout", int'(bout), 0);
        end else begin
            logic exp_busy, exp_done;
            exp_busy = (sb.size() > 0) && (cyc >= sb[0].e0) && (cyc < sb[0].dc);
            exp_done = (sb.size() > 0) && (cyc == sb[0].dc);
            chk("busy", int'(busy), int'(exp_busy));
            chk("done", int'(done), int'(exp_done));
            if (exp_done) begin
                hold_d  = sb[0].d;
                hold_bo = sb[0].bo;
                void'(sb.pop_front());
            end
            chk("diff", int'(diff), int'(hold_d));
            chk("bout", int'(bout), int'(hold_bo));
        end
    end

    initial begin
        idle(0);
        drive('0, '0, 1'b0, 1'b1);
        drive('0, '0, 1'b0, 1'b1);
        idle(2);

        run_op(8'd5,   8'd3);
        run_op(8'd3,   8'd5);
        run_op(8'd0,   8'd1);
        run_op(8'd255, 8'd255);
        run_op(8'd0,   8'd0);

        // start during RUN must be ignored
        drive(8'd200, 8'd100, 1'b1, 1'b0);
        idle(2);
        drive(8'd1, 8'd2, 1'b1, 1'b0);
        idle(W + 4);

        // back-to-back through the DONE cycle
        drive(8'd10, 8'd4, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) drive(8'd10, 8'd4, 1'b1, 1'b0);
        drive(8'd4, 8'd10, 1'b1, 1'b0);
        idle(W + 3);

        // reset mid-operation, then a fresh operation
        drive(8'd9, 8'd1, 1'b1, 1'b0);
        idle(3);
        drive('0, '0, 1'b0, 1'b1);
        idle(W + 3);
        run_op(8'd7, 8'd7);

        // reset wins over a simultaneous start
        drive(8'd1, 8'd2, 1'b1, 1'b1);
        idle(3);

        for (int i = 0; i < 800; i++) begin
            drive(W'($urandom), W'($urandom),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0));
        end

        idle(2 * W + 4);
        chk("pending_ops_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
